data_mem_be: RTL and testbench

Parametrised synchronous data memory with byte lanes. It is the next-generation MIPS data memory. It supports byte, halfword, word and (for 64-bit builds) doubleword loads and stores, with zero- or sign-extension on loads and detection of misaligned or illegal accesses. A one-cycle registered read port replaces the combinational one. An optional post-reset clear sequencer zeroes the array before the block reports ready. It sits between the ALU address path and the writeback mux of the datapath.

---
 rtl/data_mem_be.sv | 175 +++++++++++++++++
 tb/tb_data_mem_be.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_be.sv
// data_mem_be: byte-lane data memory with sized, extended loads,
// one-cycle registered read, error flag and optional post-reset clear.
// Ports: clk, rst_n | a, din, size, sext, mread, mwrite | dout, ready, misalign
module data_mem_be #(
  parameter int W              = 32,
  parameter int L              = 256,
  parameter     INIT_FILE      = "memdata.dat",
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int OB            = $clog2(W / 8),
  localparam int AW            = $clog2(L) + OB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a,
  input  logic [W-1:0]  din,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic          mread,
  input  logic          mwrite,
  output logic [W-1:0]  dout,
  output logic          ready,
  output logic          misalign
);

  localparam int NB = W / 8;
  localparam int IW = AW - OB;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  localparam state_e RST_STATE =
    CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_e        state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          ready_q, ready_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          misalign_q, misalign_d;

  logic [W-1:0]  mem_q [L];

  logic [IW-1:0] widx;
  logic [OB-1:0] ofs;

  assign widx = a[AW-1:OB];
  assign ofs  = a[OB-1:0];

  // Request decode
  logic       acc;
  logic       illegal;
  logic       unaligned;
  logic       err;
  logic       wr_ok;
  logic       rd_ok;
  logic [3:0] nb4;
  logic [3:0] a_lo;

  always_comb begin
    nb4       = 4'd1 << size;
    a_lo      = 4'(a);
    acc       = ready_q & (mread | mwrite);
    illegal   = int'(size) > OB;
    unaligned = |(a_lo & (nb4 - 4'd1));
    err       = illegal | unaligned;
    wr_ok     = acc & mwrite & ~err;
    rd_ok     = acc & mread & ~err;
  end

  // Store lanes: din bytes 0..nb-1 land on lanes ofs..ofs+nb-1
  logic [NB-1:0] be;
  logic [W-1:0]  wsh;

  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(ofs)) &&
              (i < int'(ofs) + int'(nb4));
    end
    wsh = din << {ofs, 3'b000};
  end

  // Single write port shared by clear and stores.
  // ready_q drops asynchronously on reset, so a
  // store can never commit on a reset edge.
  logic          mem_we;
  logic [IW-1:0] mem_wa;
  logic [NB-1:0] mem_be;
  logic [W-1:0]  mem_wd;

  always_comb begin
    mem_we = wr_ok;
    mem_wa = widx;
    mem_be = be;
    mem_wd = wsh;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt_q;
      mem_be = '1;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
        end
      end
    end
  end

  // Load path: read-first, so a same-edge store
  // is not visible in this result.
  logic [W-1:0] rword;
  logic [W-1:0] rsh;
  logic [W-1:0] rext;
  logic         rtop;
  int           nbits;

  always_comb begin
    rword = mem_q[widx];
    rsh   = rword >> {ofs, 3'b000};
    nbits = 8 * int'(nb4);
    rtop  = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (j == nbits - 1) rtop = rsh[j];
    end
    rext = rsh;
    for (int j = 0; j < W; j++) begin
      if (j >= nbits) rext[j] = sext & rtop;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    dout_d     = dout_q;
    misalign_d = 1'b0;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + IW'(1);
      if (clr_cnt_q == IW'(L - 1)) begin
        state_d = S_IDLE;
      end
    end else begin
      if (rd_ok) dout_d = rext;
      misalign_d = acc & err;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      dout_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ready_q    <= ready_d;
      dout_q     <= dout_d;
      misalign_q <= misalign_d;
    end
  end

  assign dout     = dout_q;
  assign ready    = ready_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed bench with a scoreboard
// for a 32-bit and a 64-bit data_mem_be build.
module tb_data_mem_be;

  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;
  localparam logic [1:0] SD = 2'd3;

  logic        clk = 1'b0;
  logic        rst32_n = 1'b0;
  logic        rst64_n = 1'b0;
  logic [6:0]  a = '0;
  logic [63:0] din = '0;
  logic [1:0]  size = '0;
  logic        sext = 1'b0;
  logic        mread32 = 1'b0;
  logic        mwrite32 = 1'b0;
  logic        mread64 = 1'b0;
  logic        mwrite64 = 1'b0;
  logic [31:0] dout32;
  logic [63:0] dout64;
  logic        rdy32, rdy64, mis32, mis64;

  data_mem_be #(
    .W(32), .L(32), .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)
  ) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .a(a), .din(din[31:0]),
    .size(size), .sext(sext), .mread(mread32),
    .mwrite(mwrite32), .dout(dout32), .ready(rdy32),
    .misalign(mis32)
  );

  data_mem_be #(
    .W(64), .L(16), .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)
  ) u_dut64 (
    .clk(clk), .rst_n(rst64_n), .a(a), .din(din),
    .size(size), .sext(sext), .mread(mread64),
    .mwrite(mwrite64), .dout(dout64), .ready(rdy64),
    .misalign(mis64)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int idn = 0;

  typedef struct {
    logic [63:0] d;
    logic        m;
    int          id;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  logic [63:0] last32 = '0;
  logic [63:0] last64 = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: a request accepted on an edge is
  // checked at the following falling edge.
  logic pend32 = 1'b0;
  logic pend64 = 1'b0;

  always @(posedge clk) begin
    pend32 <= rdy32 & (mread32 | mwrite32);
    pend64 <= rdy64 & (mread64 | mwrite64);
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend32) begin
      if (q32.size() == 0) begin
        chk("q32 underflow", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk($sformatf("dout32 #%0d", e.id),
            {32'b0, dout32}, e.d);
        chk($sformatf("mis32 #%0d", e.id),
            {63'b0, mis32}, {63'b0, e.m});
      end
    end
    if (pend64) begin
      if (q64.size() == 0) begin
        chk("q64 underflow", 64'd1, 64'd0);
      end else begin
        e = q64.pop_front();
        chk($sformatf("dout64 #%0d", e.id), dout64, e.d);
        chk($sformatf("mis64 #%0d", e.id),
            {63'b0, mis64}, {63'b0, e.m});
      end
    end
  end

  task automatic issue(input bit d64, input bit rd,
                       input bit wr, input logic [6:0] ad,
                       input logic [1:0] sz, input bit sx,
                       input logic [63:0] wd,
                       input logic [63:0] exp,
                       input bit mis);
    exp_t e;
    @(negedge clk);
    a        = ad;
    size     = sz;
    sext     = sx;
    din      = wd;
    mread32  = !d64 && rd;
    mwrite32 = !d64 && wr;
    mread64  = d64 && rd;
    mwrite64 = d64 && wr;
    e.m  = mis;
    e.id = idn;
    idn++;
    if (d64) begin
      if (rd && !mis) last64 = exp;
      e.d = last64;
      q64.push_back(e);
    end else begin
      if (rd && !mis) last32 = exp;
      e.d = last32;
      q32.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    mread32  = 1'b0;
    mwrite32 = 1'b0;
    mread64  = 1'b0;
    mwrite64 = 1'b0;
  endtask

  task automatic idle_chk32(input string nm);
    idle();
    @(negedge clk);
    chk({nm, " mis clr"}, {63'b0, mis32}, 64'd0);
    chk({nm, " hold"}, {32'b0, dout32}, last32);
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst dout32", {32'b0, dout32}, 64'd0);
    chk("rst mis32", {63'b0, mis32}, 64'd0);
    chk("rst rdy32", {63'b0, rdy32}, 64'd0);
    chk("rst dout64", dout64, 64'd0);
    chk("rst rdy64", {63'b0, rdy64}, 64'd0);
    // misaligned load held during clear must be ignored
    a       = 7'h01;
    size    = SH;
    mread32 = 1'b1;
    rst32_n = 1'b1;
    rst64_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk($sformatf("rdy32 e%0d", k),
          {63'b0, rdy32}, {63'b0, k >= 32});
      chk($sformatf("rdy64 e%0d", k),
          {63'b0, rdy64}, {63'b0, k >= 25});
      chk($sformatf("clr mis32 e%0d", k),
          {63'b0, mis32}, 64'd0);
      chk($sformatf("clr dout32 e%0d", k),
          {32'b0, dout32}, 64'd0);
      if (k == 8) rst64_n = 1'b0;
      if (k == 9) rst64_n = 1'b1;
      if (k == 32) mread32 = 1'b0;
    end

    issue(0, 1, 0, 7'h7C, SW, 0, 0, 64'h0, 0);
    issue(0, 0, 1, 7'h10, SW, 0, 64'h80FF7F01, 0, 0);
    issue(0, 1, 0, 7'h10, SB, 1, 0, 64'h00000001, 0);
    issue(0, 1, 0, 7'h13, SB, 1, 0, 64'hFFFFFF80, 0);
    issue(0, 1, 0, 7'h13, SB, 0, 0, 64'h00000080, 0);
    issue(0, 1, 0, 7'h12, SH, 1, 0, 64'hFFFF80FF, 0);
    issue(0, 1, 0, 7'h12, SH, 0, 0, 64'h000080FF, 0);
    issue(0, 1, 0, 7'h10, SW, 1, 0, 64'h80FF7F01, 0);

    issue(0, 0, 1, 7'h20, SW, 0, 64'h11223344, 0, 0);
    issue(0, 0, 1, 7'h21, SB, 0, 64'h123456AB, 0, 0);
    issue(0, 0, 1, 7'h22, SH, 0, 64'h9876CDEF, 0, 0);
    issue(0, 1, 0, 7'h20, SW, 0, 0, 64'hCDEFAB44, 0);

    issue(0, 1, 0, 7'h05, SH, 1, 0, 0, 1);
    idle_chk32("lh 05");
    issue(0, 0, 1, 7'h02, SW, 0, 64'hAAAAAAAA, 0, 1);
    idle_chk32("sw 02");
    issue(0, 1, 0, 7'h20, SD, 0, 0, 0, 1);
    idle_chk32("ld w32");
    issue(0, 0, 1, 7'h20, SD, 0, 64'hFFFFFFFF, 0, 1);
    issue(0, 0, 1, 7'h03, SH, 0, 64'hFFFFFFFF, 0, 1);
    issue(0, 1, 0, 7'h00, SW, 0, 0, 64'h00000000, 0);
    issue(0, 1, 0, 7'h20, SW, 0, 0, 64'hCDEFAB44, 0);

    issue(0, 0, 1, 7'h40, SW, 0, 64'h12345678, 0, 0);
    issue(0, 1, 1, 7'h40, SW, 0, 64'hDEADBEEF,
          64'h12345678, 0);
    issue(0, 1, 0, 7'h40, SW, 0, 0, 64'hDEADBEEF, 0);
    issue(0, 0, 1, 7'h7C, SW, 0, 64'hCAFEF00D, 0, 0);
    issue(0, 1, 0, 7'h7C, SW, 0, 0, 64'hCAFEF00D, 0);

    issue(1, 0, 1, 7'h08, SD, 0,
          64'h0123456789ABCDEF, 0, 0);
    issue(1, 1, 0, 7'h0C, SW, 1, 0,
          64'h0000000001234567, 0);
    issue(1, 1, 0, 7'h08, SW, 1, 0,
          64'hFFFFFFFF89ABCDEF, 0);
    issue(1, 1, 0, 7'h08, SD, 1, 0,
          64'h0123456789ABCDEF, 0);
    issue(1, 1, 0, 7'h0F, SB, 1, 0,
          64'h0000000000000001, 0);
    issue(1, 1, 0, 7'h08, SB, 1, 0,
          64'hFFFFFFFFFFFFFFEF, 0);
    issue(1, 1, 0, 7'h0A, SH, 0, 0,
          64'h00000000000089AB, 0);
    issue(1, 1, 0, 7'h0A, SH, 1, 0,
          64'hFFFFFFFFFFFF89AB, 0);
    issue(1, 1, 0, 7'h04, SD, 0, 0, 0, 1);
    issue(1, 0, 1, 7'h0E, SW, 0, 64'h0, 0, 1);
    issue(1, 1, 0, 7'h08, SD, 0, 0,
          64'h0123456789ABCDEF, 0);

    idle();
    rst32_n = 1'b0;
    #1;
    chk("rst2 dout32", {32'b0, dout32}, 64'd0);
    chk("rst2 rdy32", {63'b0, rdy32}, 64'd0);
    last32 = '0;
    @(negedge clk);
    rst32_n = 1'b1;
    n = 0;
    while (!rdy32 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("clear len", 64'(n), 64'd32);
    issue(0, 1, 0, 7'h10, SW, 0, 0, 64'h0, 0);
    issue(0, 1, 0, 7'h7C, SW, 0, 0, 64'h0, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("q32 drained", 64'(q32.size()), 64'd0);
    chk("q64 drained", 64'(q64.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
